// File: rtl/lsu_commit_arb.sv
// Merges the LSU load-commit and store-commit streams into one registered commit stream with a 2-entry skid buffer.
// Optional build macro LSU_COMMIT_PERF_EN adds 32-bit accepted-beat and stall-cycle counters.
module lsu_commit_arb #(
    parameter int NUM_THREADS = 4,
    parameter int NW_BITS     = 2,
    parameter int NR_BITS     = 5
) (
    input  logic                      clk,
    input  logic                      reset,

    input  logic                      ld_valid,
    output logic                      ld_ready,
    input  logic [NW_BITS-1:0]        ld_wid,
    input  logic [NUM_THREADS-1:0]    ld_tmask,
    input  logic [31:0]               ld_pc,
    input  logic [NR_BITS-1:0]        ld_rd,
    input  logic                      ld_wb,
    input  logic                      ld_eop,
    input  logic [NUM_THREADS*32-1:0] ld_data,

    input  logic                      st_valid,
    output logic                      st_ready,
    input  logic [NW_BITS-1:0]        st_wid,
    input  logic [NUM_THREADS-1:0]    st_tmask,
    input  logic [31:0]               st_pc,
    input  logic [NR_BITS-1:0]        st_rd,
    input  logic                      st_wb,
    input  logic                      st_eop,
    input  logic [NUM_THREADS*32-1:0] st_data,

    output logic                      cmt_valid,
    input  logic                      cmt_ready,
    output logic [NW_BITS-1:0]        cmt_wid,
    output logic [NUM_THREADS-1:0]    cmt_tmask,
    output logic [31:0]               cmt_pc,
    output logic [NR_BITS-1:0]        cmt_rd,
    output logic                      cmt_wb,
    output logic                      cmt_eop,
    output logic [NUM_THREADS*32-1:0] cmt_data,
    output logic                      cmt_src
`ifdef LSU_COMMIT_PERF_EN
    ,
    output logic [31:0]               perf_ld_beats,
    output logic [31:0]               perf_st_beats,
    output logic [31:0]               perf_stall_cycles
`endif
);

    typedef struct packed {
        logic                      src;
        logic [NW_BITS-1:0]        wid;
        logic [NUM_THREADS-1:0]    tmask;
        logic [31:0]               pc;
        logic [NR_BITS-1:0]        rd;
        logic                      wb;
        logic                      eop;
        logic [NUM_THREADS*32-1:0] data;
    } beat_t;

    beat_t main_q, main_d, skid_q, skid_d, in_beat;
    logic  main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
    logic  lock_q, lock_d, rr_q, rr_d;
    logic  grant_ld, open, ld_fire, st_fire, accept, retire;

    // Grant depends only on valids and registered lock/rr; when nothing is valid rr picks.
    always_comb begin
        grant_ld = 1'b0;
        if (lock_q)
            grant_ld = 1'b1;
        else if (ld_valid && !st_valid)
            grant_ld = 1'b1;
        else if (st_valid && !ld_valid)
            grant_ld = 1'b0;
        else
            grant_ld = !rr_q;
    end

    assign open     = !skid_valid_q && !reset;
    assign ld_ready = open && grant_ld;
    assign st_ready = open && !grant_ld;
    assign ld_fire  = ld_valid && ld_ready;
    assign st_fire  = st_valid && st_ready;
    assign accept   = ld_fire || st_fire;
    assign retire   = main_valid_q && cmt_ready;

    always_comb begin
        in_beat = '0;
        if (ld_fire)
            in_beat = '{src: 1'b0, wid: ld_wid, tmask: ld_tmask, pc: ld_pc, rd: ld_rd,
                        wb: ld_wb, eop: ld_eop, data: ld_data};
        else
            in_beat = '{src: 1'b1, wid: st_wid, tmask: st_tmask, pc: st_pc, rd: st_rd,
                        wb: st_wb, eop: st_eop, data: st_data};
    end

    always_comb begin
        main_d       = main_q;
        main_valid_d = main_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        lock_d       = lock_q;
        rr_d         = rr_q;

        // Accepts only happen while skid is empty, so the full-skid case is a pure drain.
        if (skid_valid_q) begin
            if (retire) begin
                main_d       = skid_q;
                skid_valid_d = 1'b0;
            end
        end else if (accept) begin
            if (!main_valid_q || retire) begin
                main_d       = in_beat;
                main_valid_d = 1'b1;
            end else begin
                skid_d       = in_beat;
                skid_valid_d = 1'b1;
            end
        end else if (retire) begin
            main_valid_d = 1'b0;
        end

        if (ld_fire)
            lock_d = !ld_eop;
        if (accept && in_beat.eop)
            rr_d = !in_beat.src;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            lock_q       <= 1'b0;
            rr_q         <= 1'b0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            lock_q       <= lock_d;
            rr_q         <= rr_d;
        end
    end

    assign cmt_valid = main_valid_q;
    assign cmt_src   = main_q.src;
    assign cmt_wid   = main_q.wid;
    assign cmt_tmask = main_q.tmask;
    assign cmt_pc    = main_q.pc;
    assign cmt_rd    = main_q.rd;
    assign cmt_wb    = main_q.wb;
    assign cmt_eop   = main_q.eop;
    assign cmt_data  = main_q.data;

`ifdef LSU_COMMIT_PERF_EN
    logic [31:0] perf_ld_q, perf_st_q, perf_stall_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_ld_q    <= '0;
            perf_st_q    <= '0;
            perf_stall_q <= '0;
        end else begin
            if (ld_fire)
                perf_ld_q <= perf_ld_q + 32'd1;
            if (st_fire)
                perf_st_q <= perf_st_q + 32'd1;
            if (main_valid_q && !cmt_ready)
                perf_stall_q <= perf_stall_q + 32'd1;
        end
    end

    assign perf_ld_beats     = perf_ld_q;
    assign perf_st_beats     = perf_st_q;
    assign perf_stall_cycles = perf_stall_q;
`endif

endmodule

// File: tb/tb_lsu_commit_arb.sv
// Directed, table-driven check of lsu_commit_arb: arbitration order, packet locking, backpressure and reset.
// Define LSU_COMMIT_PERF_EN to also check the performance counters.
module tb_lsu_commit_arb;

    typedef struct packed {
        logic [1:0]   wid;
        logic [3:0]   tmask;
        logic [31:0]  pc;
        logic [4:0]   rd;
        logic         wb;
        logic [127:0] data;
    } fields_t;

    typedef struct {
        bit lv, le, sv, se, cr;
        bit xlr, xsr, xcv, xsrc;
        int xpc;
    } vec_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         ld_valid, ld_ready, ld_wb, ld_eop;
    logic [1:0]   ld_wid;
    logic [3:0]   ld_tmask;
    logic [31:0]  ld_pc;
    logic [4:0]   ld_rd;
    logic [127:0] ld_data;
    logic         st_valid, st_ready, st_wb, st_eop;
    logic [1:0]   st_wid;
    logic [3:0]   st_tmask;
    logic [31:0]  st_pc;
    logic [4:0]   st_rd;
    logic [127:0] st_data;
    logic         cmt_valid, cmt_ready, cmt_wb, cmt_eop, cmt_src;
    logic [1:0]   cmt_wid;
    logic [3:0]   cmt_tmask;
    logic [31:0]  cmt_pc;
    logic [4:0]   cmt_rd;
    logic [127:0] cmt_data;
`ifdef LSU_COMMIT_PERF_EN
    logic [31:0]  perf_ld_beats, perf_st_beats, perf_stall_cycles;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    vec_t vt[20];

    always #5 clk = ~clk;

    lsu_commit_arb #(.NUM_THREADS(4), .NW_BITS(2), .NR_BITS(5)) dut (
        .clk(clk), .reset(reset),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_wid(ld_wid), .ld_tmask(ld_tmask),
        .ld_pc(ld_pc), .ld_rd(ld_rd), .ld_wb(ld_wb), .ld_eop(ld_eop), .ld_data(ld_data),
        .st_valid(st_valid), .st_ready(st_ready), .st_wid(st_wid), .st_tmask(st_tmask),
        .st_pc(st_pc), .st_rd(st_rd), .st_wb(st_wb), .st_eop(st_eop), .st_data(st_data),
        .cmt_valid(cmt_valid), .cmt_ready(cmt_ready), .cmt_wid(cmt_wid), .cmt_tmask(cmt_tmask),
        .cmt_pc(cmt_pc), .cmt_rd(cmt_rd), .cmt_wb(cmt_wb), .cmt_eop(cmt_eop),
        .cmt_data(cmt_data), .cmt_src(cmt_src)
`ifdef LSU_COMMIT_PERF_EN
        ,
        .perf_ld_beats(perf_ld_beats), .perf_st_beats(perf_st_beats),
        .perf_stall_cycles(perf_stall_cycles)
`endif
    );

    // Stimulus fields derived from a tag; loads carry tmask 1011 and lanes ..11/..22/..33/..44.
    function automatic fields_t mk(input bit src, input int tag);
        fields_t f;
        f.pc    = 32'(tag);
        f.wid   = f.pc[1:0];
        f.tmask = src ? 4'b0110 : 4'b1011;
        f.rd    = f.pc[6:2];
        f.wb    = !src;
        for (int k = 0; k < 4; k++)
            f.data[k*32 +: 32] = {f.pc[23:0], 8'((k + 1) * 17)};
        return f;
    endfunction

    function automatic vec_t v(input bit lv, le, sv, se, cr, xlr, xsr, xcv, xsrc, input int xpc);
        vec_t r;
        r.lv = lv; r.le = le; r.sv = sv; r.se = se; r.cr = cr;
        r.xlr = xlr; r.xsr = xsr; r.xcv = xcv; r.xsrc = xsrc; r.xpc = xpc;
        return r;
    endfunction

    task automatic chk(input string nm, input int step, input logic [199:0] got, input logic [199:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %0h required %0h", nm, step, got, exp);
        end
    endtask

    task automatic drive(input bit lv, le, input int ltag, input bit sv, se, input int stag, input bit cr);
        fields_t lf, sf;
        lf = mk(1'b0, ltag);
        sf = mk(1'b1, stag);
        ld_valid = lv; ld_eop = le;
        {ld_wid, ld_tmask, ld_pc, ld_rd, ld_wb, ld_data} = lf;
        st_valid = sv; st_eop = se;
        {st_wid, st_tmask, st_pc, st_rd, st_wb, st_data} = sf;
        cmt_ready = cr;
    endtask

    task automatic chk_cmt(input string nm, input int step, input bit src, input int tag, input bit eop);
        chk({nm, "_valid"}, step, 200'(cmt_valid), 200'(1));
        chk({nm, "_src"},   step, 200'(cmt_src), 200'(src));
        chk({nm, "_eop"},   step, 200'(cmt_eop), 200'(eop));
        chk({nm, "_fields"}, step, 200'({cmt_wid, cmt_tmask, cmt_pc, cmt_rd, cmt_wb, cmt_data}),
            200'(mk(src, tag)));
    endtask

    initial begin
        // Ld tags are 1000+step, st tags 2000+step; expectations reflect beats accepted in earlier steps.
        vt[0]  = v(1,1,1,1,1, 1,0, 0,0,0);
        vt[1]  = v(1,1,1,1,1, 0,1, 1,0,1000);
        vt[2]  = v(1,1,1,1,1, 1,0, 1,1,2001);
        vt[3]  = v(1,1,1,1,1, 0,1, 1,0,1002);
        vt[4]  = v(0,0,0,0,1, 0,0, 1,1,2003);
        vt[5]  = v(1,1,0,0,1, 1,0, 0,0,0);
        vt[6]  = v(0,0,0,0,1, 0,0, 1,0,1005);
        vt[7]  = v(0,0,1,1,1, 0,1, 0,0,0);
        vt[8]  = v(1,0,1,1,1, 1,0, 1,1,2007);
        vt[9]  = v(1,0,1,1,1, 1,0, 1,0,1008);
        vt[10] = v(1,1,1,1,1, 1,0, 1,0,1009);
        vt[11] = v(0,0,1,1,1, 0,1, 1,0,1010);
        vt[12] = v(0,0,0,0,1, 0,0, 1,1,2011);
        vt[13] = v(1,1,0,0,0, 1,0, 0,0,0);
        vt[14] = v(1,1,0,0,0, 1,0, 1,0,1013);
        vt[15] = v(1,1,0,0,0, 0,0, 1,0,1013);
        vt[16] = v(1,1,0,0,0, 0,0, 1,0,1013);
        vt[17] = v(1,1,0,0,1, 0,0, 1,0,1013);
        vt[18] = v(1,1,0,0,1, 1,0, 1,0,1014);
        vt[19] = v(0,0,0,0,1, 0,0, 1,0,1018);

        reset = 1'b1;
        drive(1, 1, 1, 1, 1, 2, 1);
        @(negedge clk);
        chk("rst_ld_ready", -1, 200'(ld_ready), 200'(0));
        chk("rst_st_ready", -1, 200'(st_ready), 200'(0));
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 0, 1);
        @(posedge clk); #1;
        reset = 1'b0;
        chk("rst_cmt_valid", -1, 200'(cmt_valid), 200'(0));
        chk("rst_cmt_src",   -1, 200'(cmt_src), 200'(0));
        chk("rst_cmt_fields", -1, 200'({cmt_wid, cmt_tmask, cmt_pc, cmt_rd, cmt_wb, cmt_eop, cmt_data}), 200'(0));
`ifdef LSU_COMMIT_PERF_EN
        chk("rst_perf", -1, 200'({perf_ld_beats, perf_st_beats, perf_stall_cycles}), 200'(0));
`endif

        for (int i = 0; i < 20; i++) begin
            int idx;
            drive(vt[i].lv, vt[i].le, 1000 + i, vt[i].sv, vt[i].se, 2000 + i, vt[i].cr);
            @(negedge clk);
            if (vt[i].lv || vt[i].sv) begin
                chk("ld_ready", i, 200'(ld_ready), 200'(vt[i].xlr));
                chk("st_ready", i, 200'(st_ready), 200'(vt[i].xsr));
            end
            if (vt[i].xcv) begin
                idx = vt[i].xpc % 1000;
                chk_cmt("cmt", i, vt[i].xsrc, vt[i].xpc, vt[i].xsrc ? vt[idx].se : vt[idx].le);
            end else begin
                chk("cmt_valid", i, 200'(cmt_valid), 200'(0));
            end
            $display("[TB] step %0d lv=%0d sv=%0d cr=%0d -> ld_rdy=%0d st_rdy=%0d cmt_v=%0d src=%0d pc=%0d",
                     i, vt[i].lv, vt[i].sv, vt[i].cr, ld_ready, st_ready, cmt_valid, cmt_src, cmt_pc);
            @(posedge clk); #1;
        end
`ifdef LSU_COMMIT_PERF_EN
        chk("perf_ld_beats",     20, 200'(perf_ld_beats), 200'(9));
        chk("perf_st_beats",     20, 200'(perf_st_beats), 200'(4));
        chk("perf_stall_cycles", 20, 200'(perf_stall_cycles), 200'(3));
`endif

        // Reset in the middle of a multi-beat load; a waiting store must then win at once.
        drive(1, 0, 3000, 0, 1, 0, 1);
        @(negedge clk);
        chk("mid_ld_ready", 30, 200'(ld_ready), 200'(1));
        @(posedge clk); #1;
        reset = 1'b1;
        drive(0, 1, 0, 1, 1, 3001, 1);
        @(negedge clk);
        chk("mid_rst_ld_ready", 31, 200'(ld_ready), 200'(0));
        chk("mid_rst_st_ready", 31, 200'(st_ready), 200'(0));
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("mid_cmt_valid", 32, 200'(cmt_valid), 200'(0));
        chk("mid_st_ready",  32, 200'(st_ready), 200'(1));
        chk("mid_ld_ready0", 32, 200'(ld_ready), 200'(0));
        @(posedge clk); #1;
        drive(0, 1, 0, 0, 1, 0, 1);
        @(negedge clk);
        chk_cmt("mid_cmt", 33, 1'b1, 3001, 1'b1);
        $display("[TB] mid-packet reset: cmt_v=%0d src=%0d pc=%0d", cmt_valid, cmt_src, cmt_pc);
        @(posedge clk); #1;
`ifdef LSU_COMMIT_PERF_EN
        chk("mid_perf_ld", 34, 200'(perf_ld_beats), 200'(0));
        chk("mid_perf_st", 34, 200'(perf_st_beats), 200'(1));
`endif
        chk("drain_cmt_valid", 34, 200'(cmt_valid), 200'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
